// File: rtl/fp_wire.sv
// Shared types and constants for the FPU result checker.
package fp_wire;

  // One expected-result record queued per issued vector.
  typedef struct packed {
    logic [1:0]  fmt;
    logic        f2i;
    logic [63:0] result;
    logic [4:0]  flags;
  } fp_check_entry_type;

  typedef enum logic {
    CHK_RUN  = 1'b0,
    CHK_HALT = 1'b1
  } fp_check_state_type;

  localparam logic [31:0] FP_QNAN_S = 32'h7FC0_0000;
  localparam logic [63:0] FP_QNAN_D = 64'h7FF8_0000_0000_0000;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fp_check_fifo.sv
// In-order FIFO of expected results. Pointers wrap naturally because DEPTH
// is a power of two; the occupancy counter is one bit wider than the
// pointers so full and empty are distinguishable.
module fp_check_fifo
  import fp_wire::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  fp_check_entry_type push_data,
  input  logic               pop,
  output fp_check_entry_type head,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  fp_check_entry_type mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/fp_result_checker.sv
// Self-checking consumer for fp_unit results: queues expected results,
// compares each returned result in order, counts pass/fail and halts on
// the first error (mismatch, orphan result or expected-queue overflow).
// Optional build macro FP_CHECK_NAN_RELAX_EN accepts any NaN payload/sign
// when the unit returns the canonical quiet NaN.
module fp_result_checker
  import fp_wire::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [1:0]  issue_fmt,
  input  logic        issue_f2i,
  input  logic [63:0] issue_result,
  input  logic [4:0]  issue_flags,
  output logic        issue_accept,
  input  logic        res_ready,
  input  logic [63:0] res_result,
  input  logic [4:0]  res_flags,
  output logic [31:0] pass_count,
  output logic [31:0] fail_count,
  output logic        error,
  output logic        overflow,
  output logic        orphan,
  output logic [63:0] err_expected,
  output logic [63:0] err_calc,
  output logic [4:0]  err_flags_exp,
  output logic [4:0]  err_flags_calc,
  output logic        drained
);

  fp_check_state_type state_q, state_d;
  fp_check_entry_type push_data, head;
  logic full, empty, run;
  logic push_fire, pop_fire, orphan_ev, overflow_ev, mismatch;
  logic [63:0] result_diff;
  logic [4:0]  flags_diff;

  assign run          = (state_q == CHK_RUN);
  assign pop_fire     = run && res_ready && !empty;
  assign issue_accept = run && (!full || pop_fire);
  assign push_fire    = issue_valid && issue_accept;
  assign orphan_ev    = run && res_ready && empty;
  assign overflow_ev  = run && issue_valid && full && !pop_fire;

  assign push_data = '{fmt: issue_fmt, f2i: issue_f2i,
                       result: issue_result, flags: issue_flags};

  fp_check_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_fire),
    .push_data (push_data),
    .pop       (pop_fire),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

`ifdef FP_CHECK_NAN_RELAX_EN
  // Canonical NaN from the unit matches any expected NaN: only the
  // exponent and quiet bit are compared in that case.
  always_comb begin
    result_diff = res_result ^ head.result;
    if (!head.f2i) begin
      if (head.fmt == 2'd0) begin
        if (res_result[31:0] == FP_QNAN_S) begin
          result_diff = {32'h0, 1'b0, res_result[30:22] ^ head.result[30:22], 22'h0};
        end
      end else if (res_result == FP_QNAN_D) begin
        result_diff = {1'b0, res_result[62:51] ^ head.result[62:51], 51'h0};
      end
    end
  end
`else
  // Strict build: every result bit must match.
  always_comb begin
    result_diff = res_result ^ head.result;
  end

  logic unused_head_ctl;
  assign unused_head_ctl = ^{head.fmt, head.f2i};
`endif

  assign flags_diff = res_flags ^ head.flags;
  assign mismatch   = pop_fire && ((result_diff != '0) || (flags_diff != '0));

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= CHK_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Any error event in RUN halts checking until reset.
  always_comb begin
    state_d = state_q;
    if (run && (mismatch || orphan_ev || overflow_ev)) begin
      state_d = CHK_HALT;
    end
  end

  // Counters, sticky causes and first-mismatch capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pass_count     <= '0;
      fail_count     <= '0;
      overflow       <= 1'b0;
      orphan         <= 1'b0;
      err_expected   <= '0;
      err_calc       <= '0;
      err_flags_exp  <= '0;
      err_flags_calc <= '0;
    end else begin
      if (pop_fire) begin
        if (mismatch) begin
          fail_count <= sat_inc(fail_count);
        end else begin
          pass_count <= sat_inc(pass_count);
        end
      end
      if (mismatch && !error) begin
        err_expected   <= head.result;
        err_calc       <= res_result;
        err_flags_exp  <= head.flags;
        err_flags_calc <= res_flags;
      end
      if (overflow_ev) begin
        overflow <= 1'b1;
      end
      if (orphan_ev) begin
        orphan <= 1'b1;
      end
    end
  end

  assign error   = (state_q == CHK_HALT);
  assign drained = empty && run;

endmodule
